// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Register x0 never creates a dependency.
  function automatic logic rd_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// Pending-write FIFO: DEPTH entries, pointers wrap modulo DEPTH, no bypass.
// Exposes every entry's rd plus an occupancy mask for hazard detection.
module wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  wr_req_t                        push_data,
  output wr_req_t                        head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DEPTH-1:0][REG_AW-1:0]   entry_rd,
  output logic [DEPTH-1:0]               entry_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head  = mem[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_rd    = '0;
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_rd[i]    = mem[i].rd;
      entry_valid[i] = ({1'b0, PW'(i) - rptr} < count);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging ALU and memory writebacks into one register-file
// write port through a FIFO. Define REGFILE_ARB_HAZARD_EN to build hazard logic.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [REG_AW-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   port_free,
  output logic                   RegWrite,
  output logic [REG_AW-1:0]      a3,
  output logic [DATA_W-1:0]      wd3,
  input  logic [REG_AW-1:0]      rs1,
  input  logic [REG_AW-1:0]      rs2,
  output logic                   hazard,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  logic                         last_grant;
  logic                         mem_win;
  logic                         alu_win;
  logic                         deq;
  logic                         space;
  logic                         push;
  wr_req_t                      win_req;
  wr_req_t                      head;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;
  logic [DEPTH-1:0]             entry_valid;

  // Ties go to whoever was not granted last; lone requesters always win.
  always_comb begin
    mem_win   = mem_valid && (!alu_valid || (last_grant == REQ_ALU));
    alu_win   = alu_valid && !mem_win;
    deq       = !empty && port_free;
    space     = !full || deq;
    alu_ready = !reset && alu_win && space;
    mem_ready = !reset && mem_win && space;
    win_req   = mem_win ? wr_req_t'{rd: mem_rd, data: mem_data}
                        : wr_req_t'{rd: alu_rd, data: alu_data};
    push      = (alu_ready || mem_ready) && (win_req.rd != '0);
  end

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (deq),
    .push_data   (win_req),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // x0 writes are swallowed without advancing the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_ALU;
    end else if (push) begin
      last_grant <= mem_win ? REQ_MEM : REQ_ALU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite <= 1'b0;
      a3       <= '0;
      wd3      <= '0;
    end else begin
      RegWrite <= deq;
      if (deq) begin
        a3  <= head.rd;
        wd3 <= head.data;
      end
    end
  end

`ifdef REGFILE_ARB_HAZARD_EN
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (rd_match(entry_rd[i], rs1) || rd_match(entry_rd[i], rs2)))
        hazard = 1'b1;
    end
    if (RegWrite && (rd_match(a3, rs1) || rd_match(a3, rs2))) hazard = 1'b1;
    if (reset) hazard = 1'b0;
  end
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{rs1, rs2, entry_rd, entry_valid};
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, port_free;
  logic [4:0]  alu_rd, mem_rd, rs1, rs2, a3;
  logic [31:0] alu_data, mem_data, wd3;
  logic        alu_ready, mem_ready, RegWrite, hazard, full, empty;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .port_free(port_free), .RegWrite(RegWrite), .a3(a3), .wd3(wd3),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .full(full), .empty(empty), .count(count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  wr_req_t     q[$];
  logic        m_last_mem;
  logic        m_rw;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  // Requester state: pending request held until accepted
  logic        a_pend, m_pend;
  wr_req_t     a_req, m_req;
  wr_req_t     a_src[$], m_src[$];
  logic [4:0]  wlog[$];

  function automatic logic hit(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return (r1 != 0 && r1 == rd) || (r2 != 0 && r2 == rd);
  endfunction

  task automatic model_reset();
    q.delete(); a_src.delete(); m_src.delete();
    m_last_mem = 1'b0; m_rw = 1'b0; m_a3 = '0; m_wd3 = '0;
    a_pend = 1'b0; m_pend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  // One clock: drive at edge+1, compare before the next edge, advance model.
  task automatic step(input logic pf, input logic [4:0] r1, input logic [4:0] r2);
    logic deq, win_any, win_mem, space, e_ar, e_mr, e_hz;
    wr_req_t it;
    if (!a_pend && a_src.size() > 0) begin a_req = a_src.pop_front(); a_pend = 1'b1; end
    if (!m_pend && m_src.size() > 0) begin m_req = m_src.pop_front(); m_pend = 1'b1; end
    alu_valid = a_pend; alu_rd = a_req.rd; alu_data = a_req.data;
    mem_valid = m_pend; mem_rd = m_req.rd; mem_data = m_req.data;
    port_free = pf; rs1 = r1; rs2 = r2;
    #3;
    deq     = (q.size() > 0) && pf;
    win_any = a_pend || m_pend;
    win_mem = (a_pend && m_pend) ? !m_last_mem : m_pend;
    space   = (q.size() < DEPTH) || deq;
    e_ar    = win_any && !win_mem && space;
    e_mr    = win_mem && space;
    e_hz    = 1'b0;
`ifdef REGFILE_ARB_HAZARD_EN
    foreach (q[i]) if (hit(q[i].rd, r1, r2)) e_hz = 1'b1;
    if (m_rw && hit(m_a3, r1, r2)) e_hz = 1'b1;
`endif
    check("regwrite", 32'(RegWrite), 32'(m_rw));
    check("a3", 32'(a3), 32'(m_a3));
    check("wd3", wd3, m_wd3);
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    check("hazard", 32'(hazard), 32'(e_hz));
    if (RegWrite) wlog.push_back(a3);
    if (deq) begin
      it = q.pop_front();
      m_rw = 1'b1; m_a3 = it.rd; m_wd3 = it.data;
    end else begin
      m_rw = 1'b0;
    end
    if (e_ar || e_mr) begin
      it = e_mr ? m_req : a_req;
      if (it.rd != 0) begin
        q.push_back(it);
        m_last_mem = e_mr;
      end
      if (e_mr) m_pend = 1'b0; else a_pend = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  function automatic wr_req_t mk(input logic [4:0] rd, input logic [31:0] data);
    return wr_req_t'{rd: rd, data: data};
  endfunction

  logic exp_hz;

  initial begin
    alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
    port_free = 0; rs1 = 0; rs2 = 0;
    a_req = '0; m_req = '0;
`ifdef REGFILE_ARB_HAZARD_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    do_reset();

    // Alternating grants with both requesters always valid
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      a_src.push_back(mk(5'd5, 32'h100 + 32'(i)));
      m_src.push_back(mk(5'd6, 32'h200 + 32'(i)));
    end
    for (int i = 0; i < 12; i++) step(1'b1, 5'd0, 5'd0);
    check("rr_nwrites", 32'(wlog.size()), 32'd8);
    if (wlog.size() >= 4) begin
      check("rr_w0", 32'(wlog[0]), 32'd6);
      check("rr_w1", 32'(wlog[1]), 32'd5);
      check("rr_w2", 32'(wlog[2]), 32'd6);
      check("rr_w3", 32'(wlog[3]), 32'd5);
    end
    do_reset();

    // Fill to full with port blocked, then drain
    wlog.delete();
    for (int i = 1; i <= 5; i++) a_src.push_back(mk(5'(i), 32'hA0 + 32'(i)));
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 5'd0);
    #2;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(DEPTH));
    check("fill_alu_ready", 32'(alu_ready), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd0, 5'd0);
    check("fill_nwrites", 32'(wlog.size()), 32'd5);
    foreach (wlog[i]) check("fill_order", 32'(wlog[i]), 32'(i + 1));
    do_reset();

    // Writes to x0 are accepted and dropped
    wlog.delete();
    a_src.push_back(mk(5'd0, 32'hDEADBEEF));
    for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 5'd0);
    check("x0_count", 32'(count), 32'd0);
    check("x0_nwrites", 32'(wlog.size()), 32'd0);

    // Hazard on a pending and an in-flight write
    m_src.push_back(mk(5'd9, 32'h99));
    for (int i = 0; i < 3; i++) step(1'b0, 5'd9, 5'd0);
    #2;
    check("hz_pending", 32'(hazard), 32'(exp_hz));
    for (int i = 0; i < 4; i++) step(1'b1, 5'd9, 5'd0);
    check("hz_after", 32'(hazard), 32'd0);

    // Reset mid-operation drops queued writes
    wlog.delete();
    for (int i = 1; i <= 3; i++) a_src.push_back(mk(5'(i), 32'(i)));
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0);
    check("midrst_count_before", 32'(count), 32'd3);
    #2;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'd0, 5'd0);
    check("midrst_nwrites", 32'(wlog.size()), 32'd0);

    // Full FIFO with simultaneous enqueue and dequeue
    wlog.delete();
    for (int i = 1; i <= 8; i++) a_src.push_back(mk(5'(i), 32'hC0 + 32'(i)));
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd0, 5'd0);
    step(1'b1, 5'd0, 5'd0);
    #2;
    check("full_thru_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 10; i++) step(1'b1, 5'd0, 5'd0);
    check("full_thru_nwrites", 32'(wlog.size()), 32'd8);
    foreach (wlog[i]) check("full_thru_order", 32'(wlog[i]), 32'(i + 1));
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!a_pend && a_src.size() == 0 && $urandom_range(0, 2) != 0)
        a_src.push_back(mk(5'($urandom_range(0, 7)), $urandom));
      if (!m_pend && m_src.size() == 0 && $urandom_range(0, 2) != 0)
        m_src.push_back(mk(5'($urandom_range(0, 7)), $urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, number of entries in the pending-write FIFO (power of two, 2..16).
REQ-002 The clock port SHALL be: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The reset port SHALL be: reset, input, 1 bit, asynchronous, active-high.
REQ-004 The ALU requester ports SHALL be:
- alu_valid, input, 1 bit, write request.
- alu_rd, input, 5 bits, destination register.
- alu_data, input, 32 bits, write data.
- alu_ready, output, 1 bit, request accepted this cycle.
REQ-005 The memory requester ports SHALL be:
- mem_valid, input, 1 bit, write request.
- mem_rd, input, 5 bits, destination register.
- mem_data, input, 32 bits, write data.
- mem_ready, output, 1 bit, request accepted this cycle.
REQ-006 The write-port controls SHALL be:
- port_free, input, 1 bit, the register file may take a write this cycle.
- RegWrite, output, 1 bit, write strobe.
- a3, output, 5 bits, write address.
- wd3, output, 32 bits, write data.
REQ-007 The hazard ports SHALL be:
- rs1 and rs2, inputs, 5 bits each, decode-stage source registers.
- hazard, output, 1 bit, a pending write targets rs1 or rs2.
REQ-008 The status ports SHALL be: full, output, 1 bit; empty, output, 1 bit; count, output, $clog2(DEPTH)+1 bits.

Function
REQ-009 A handshake SHALL occur when valid and ready are both high at a rising edge; data SHALL be held stable by the requester until then.
REQ-010 At most one request SHALL be enqueued per cycle, chosen by a round-robin grant: when both are valid, the requester not granted last SHALL win; a lone valid requester SHALL always win.
REQ-011 ready SHALL be high only for the granted requester, and only when the FIFO is not full or a dequeue occurs in the same cycle.
REQ-012 A request with rd == 0 SHALL be accepted and discarded without enqueueing; it SHALL NOT update the round-robin pointer.
REQ-013 A dequeue SHALL occur at a rising edge when the FIFO is not empty and port_free is high.
REQ-014 Write-port outputs SHALL be registered. In the cycle after a dequeue, RegWrite SHALL be 1 and a3/wd3 SHALL hold the dequeued entry. In all other cycles RegWrite SHALL be 0 and a3/wd3 SHALL hold their last values.
REQ-015 Minimum latency from acceptance to RegWrite high SHALL be two edges: the enqueue edge and then the dequeue edge. The FIFO SHALL have no bypass path.
REQ-016 Writes SHALL leave in acceptance order, with no coalescing of equal rd.
REQ-017 A simultaneous enqueue and dequeue SHALL keep count unchanged, including when the FIFO is full or holds one entry.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH. full SHALL be (count == DEPTH) and empty SHALL be (count == 0).
REQ-019 hazard SHALL be combinational. It SHALL be high when a nonzero rs1 or rs2 equals the rd of any valid FIFO entry, or equals a3 while RegWrite is high.

Reset
REQ-020 Reset SHALL clear the FIFO (pointers and count to 0) and set RegWrite, a3 and wd3 to 0. It SHALL set the round-robin pointer so that mem wins the first tie.
REQ-021 During reset, alu_ready, mem_ready and hazard SHALL be 0, and empty SHALL be 1.
REQ-022 Reset asserted mid-operation SHALL drop all pending writes with no RegWrite pulse. The first acceptance SHALL be possible at the first edge after deassertion.

Configuration
REQ-023 When REGFILE_ARB_HAZARD_EN is defined, hazard SHALL behave per REQ-019. When it is undefined, hazard SHALL be tied to 0 and no comparators SHALL be built.

Structure
REQ-024 A shared package SHALL hold the wr_req_t struct (rd[4:0], data[31:0]), the requester-index constants REQ_ALU=0 and REQ_MEM=1, and the register-address width constant.
REQ-025 The FIFO SHALL be a sub-module named wr_fifo, parameterised by DEPTH, exposing its entry rd values for hazard comparison. Arbitration and output registers SHALL stay in the top module.

Verification
REQ-026 Both requesters valid every cycle with port_free=1, alu rd=5 and mem rd=6 -> grants alternate mem, alu, mem, alu; RegWrite writes a3 = 6, 5, 6, 5.
REQ-027 port_free=0 with alu pushing rd 1..5 at DEPTH=4 -> four accepts, full=1, alu_ready=0 on the fifth; port_free=1 -> writes 1,2,3,4, then 5 is accepted on the first cycle a dequeue occurs.
REQ-028 alu rd=0 with data 0xDEADBEEF -> alu_ready=1, count stays 0, no RegWrite pulse.
REQ-029 mem writes rd=9 with port_free=0 and rs1=9 -> hazard=1; port_free=1 -> hazard=1 during the RegWrite cycle, then 0. Without REGFILE_ARB_HAZARD_EN, hazard stays 0 throughout.
REQ-030 Three entries queued, reset pulsed between edges -> count=0, RegWrite=0 immediately; no write occurs after deassertion.
REQ-031 Full FIFO, port_free=1, alu valid -> enqueue and dequeue on the same edge, count stays DEPTH, order preserved.
